// File: rtl/plane_setup_sched_pkg.sv
// Shared types and constants for the plane-setup scheduler: FSM state encoding,
// attribute slot indices and the attribute index width.
package plane_setup_sched_pkg;

  localparam int ATTR_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    READY = 3'd5
  } state_t;

  localparam logic [ATTR_IDX_W-1:0] ATTR_Z      = 3'd0;
  localparam logic [ATTR_IDX_W-1:0] ATTR_W      = 3'd1;
  localparam logic [ATTR_IDX_W-1:0] ATTR_U      = 3'd2;
  localparam logic [ATTR_IDX_W-1:0] ATTR_V      = 3'd3;
  localparam logic [ATTR_IDX_W-1:0] ATTR_BASE_0 = 3'd4;
  localparam logic [ATTR_IDX_W-1:0] ATTR_BASE_1 = 3'd5;
  localparam logic [ATTR_IDX_W-1:0] ATTR_OFFS_0 = 3'd6;
  localparam logic [ATTR_IDX_W-1:0] ATTR_OFFS_1 = 3'd7;

endpackage

// File: rtl/plane_setup_sched_prio_enc_lsb.sv
// Lowest-set-bit finder: returns the index of the least significant 1 in vec,
// and whether any bit is set at all.
module prio_enc_lsb
  import plane_setup_sched_pkg::*;
#(
  parameter int NUM_ATTR = 8
) (
  input  logic [NUM_ATTR-1:0]   vec,
  output logic [ATTR_IDX_W-1:0] idx,
  output logic                  any
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_ATTR - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ATTR_IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plane_setup_sched.sv
// Sequences one shared plane-setup datapath over the enabled attributes of a
// triangle, writes the coefficient bank, and culls degenerate or stalled triangles.
module plane_setup_sched
  import plane_setup_sched_pkg::*;
#(
  parameter int NUM_ATTR = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [NUM_ATTR-1:0]   attr_mask,
  output logic                  su_setup,
  output logic [ATTR_IDX_W-1:0] su_attr,
  input  logic                  su_done,
  input  logic                  su_degen,
  output logic                  coef_we,
  output logic [ATTR_IDX_W-1:0] coef_addr,
  output logic                  params_valid,
  input  logic                  params_ack,
  output logic                  tri_culled,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic [NUM_ATTR-1:0]     pending;
  logic [CNT_W-1:0]        wait_cnt;
  logic [ATTR_IDX_W-1:0]   lsb_idx;
  logic                    lsb_any;
  logic                    timeout_hit;

  prio_enc_lsb #(.NUM_ATTR(NUM_ATTR)) u_prio_enc_lsb (
    .vec (pending),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  // The counter reaches TIMEOUT on this cycle's increment.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tri_ready    <= 1'b1;
      pending      <= '0;
      wait_cnt     <= '0;
      su_setup     <= 1'b0;
      su_attr      <= '0;
      coef_we      <= 1'b0;
      coef_addr    <= '0;
      params_valid <= 1'b0;
      tri_culled   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      su_setup   <= 1'b0;
      coef_we    <= 1'b0;
      tri_culled <= 1'b0;
      case (state)
        IDLE: begin
          if (tri_valid) begin
            pending   <= attr_mask;
            tri_ready <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (lsb_any) begin
            su_attr  <= lsb_idx;
            su_setup <= 1'b1;
            state    <= ISSUE;
          end else begin
            params_valid <= 1'b1;
            state        <= READY;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (su_done && su_degen) begin
            tri_culled <= 1'b1;
            pending    <= '0;
            tri_ready  <= 1'b1;
            state      <= IDLE;
          end else if (su_done) begin
            coef_we   <= 1'b1;
            coef_addr <= su_attr;
            state     <= WRITE;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            tri_culled  <= 1'b1;
            pending     <= '0;
            tri_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        WRITE: begin
          pending[su_attr] <= 1'b0;
          state            <= SCAN;
        end
        READY: begin
          if (params_ack) begin
            params_valid <= 1'b0;
            tri_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          tri_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plane_setup_sched.sv
// Self-checking bench for plane_setup_sched: table of triangles with a setup-unit
// responder, a scoreboard of expected su_attr/coef_addr values, and corner sequences.
module tb_plane_setup_sched;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tri_valid;
  logic       tri_ready;
  logic [7:0] attr_mask;
  logic       su_setup;
  logic [2:0] su_attr;
  logic       su_done;
  logic       su_degen;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic       params_valid;
  logic       params_ack;
  logic       tri_culled;
  logic       timeout_err;

  plane_setup_sched #(.NUM_ATTR(8), .TIMEOUT(255)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tri_valid    (tri_valid),
    .tri_ready    (tri_ready),
    .attr_mask    (attr_mask),
    .su_setup     (su_setup),
    .su_attr      (su_attr),
    .su_done      (su_done),
    .su_degen     (su_degen),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .params_valid (params_valid),
    .params_ack   (params_ack),
    .tri_culled   (tri_culled),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_setup = 0;
  int n_we = 0;
  int n_cull = 0;

  logic [2:0] exp_setup[$];
  logic [2:0] exp_we[$];

  int resp_enable = 0;
  int resp_delay = 1;
  int degen_at = 0;
  int done_ord = 1;
  int resp_cnt = 0;

  typedef struct {
    logic [7:0] mask;
    int         delay;
    int         degen;
    int         no_done;
    int         outcome;
    int         lat;
    int         terr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Setup-unit model: answers each su_setup with su_done after resp_delay cycles.
  initial begin
    su_done  = 1'b0;
    su_degen = 1'b0;
    forever begin
      @(negedge clock);
      su_done  = 1'b0;
      su_degen = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          su_done  = 1'b1;
          su_degen = (done_ord == degen_at);
          done_ord++;
        end
      end
      if (su_setup && reset_n && resp_enable != 0) resp_cnt = resp_delay;
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (su_setup) begin
          n_setup++;
          if (exp_setup.size() == 0) check("unexpected_su_setup", 1, 0);
          else check("su_attr", su_attr, exp_setup.pop_front());
        end
        if (coef_we) begin
          n_we++;
          if (exp_we.size() == 0) check("unexpected_coef_we", 1, 0);
          else check("coef_addr", coef_addr, exp_we.pop_front());
        end
        if (tri_culled) n_cull++;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!tri_ready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (!tri_ready) check("wait_tri_ready_timeout", 0, 1);
  endtask

  task automatic push_expect(input logic [7:0] m, input int dg, input int nd);
    int ord = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        ord++;
        exp_setup.push_back(3'(i));
        if (dg == ord || nd != 0) break;
        exp_we.push_back(3'(i));
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int cyc;
    int outc;
    int base_we;
    int base_setup;
    int bad;

    vecs[0] = '{8'h05, 10, 0, 0, 1, 28, 0};
    vecs[1] = '{8'hFF, 3, 3, 0, 2, 18, 0};
    vecs[2] = '{8'h01, 1, 0, 1, 2, 258, 1};
    vecs[3] = '{8'h00, 1, 0, 0, 1, 2, 1};
    vecs[4] = '{8'hA0, 1, 0, 0, 1, 10, 1};
    vecs[5] = '{8'h81, 2, 0, 0, 1, 12, 1};

    reset_n = 1'b0;
    tri_valid = 1'b0;
    attr_mask = 8'h00;
    params_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_tri_ready", tri_ready, 1);
    check("reset_outputs", {su_setup, su_attr, coef_we, coef_addr, params_valid, tri_culled, timeout_err}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      wait_idle();
      resp_enable = (vecs[v].no_done == 0) ? 1 : 0;
      resp_delay  = vecs[v].delay;
      degen_at    = vecs[v].degen;
      done_ord    = 1;
      base_we     = n_we;
      push_expect(vecs[v].mask, vecs[v].degen, vecs[v].no_done);
      tri_valid = 1'b1;
      attr_mask = vecs[v].mask;
      @(negedge clock);
      tri_valid = 1'b0;
      attr_mask = 8'h00;
      cyc = 1;
      while (!params_valid && !tri_culled && cyc < 3000) begin
        @(negedge clock);
        cyc++;
      end
      outc = params_valid ? 1 : (tri_culled ? 2 : 0);
      check($sformatf("v%0d_outcome", v), outc, vecs[v].outcome);
      check($sformatf("v%0d_latency", v), cyc, vecs[v].lat);
      check($sformatf("v%0d_timeout_err", v), timeout_err, vecs[v].terr);
      if (outc == 1) begin
        params_ack = 1'b1;
        @(negedge clock);
        params_ack = 1'b0;
        check($sformatf("v%0d_params_valid_drop", v), params_valid, 0);
      end else begin
        @(negedge clock);
      end
      check($sformatf("v%0d_tri_ready", v), tri_ready, 1);
      check($sformatf("v%0d_sb_drained", v), exp_setup.size() + exp_we.size(), 0);
      check($sformatf("v%0d_coef_we_count", v), n_we - base_we, exp_we.size() + $countones(vecs[v].mask & ~(vecs[v].mask - 8'h01)) * 0 + ((v == 1) ? 2 : $countones(vecs[v].mask) * (1 - vecs[v].no_done)));
    end
    check("cull_count", n_cull, 2);

    // Reset while waiting on attribute 3; the late su_done must be ignored.
    wait_idle();
    resp_enable = 1;
    resp_delay  = 10;
    degen_at    = 0;
    done_ord    = 1;
    base_we     = n_we;
    exp_setup.push_back(3'd3);
    tri_valid = 1'b1;
    attr_mask = 8'h08;
    @(negedge clock);
    tri_valid = 1'b0;
    attr_mask = 8'h00;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async_reset_tri_ready", tri_ready, 1);
    check("async_reset_clears", {su_attr, params_valid, timeout_err}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    check("reset_mid_wait_no_we", n_we - base_we, 0);
    check("reset_mid_wait_idle", tri_ready, 1);
    check("reset_mid_wait_sb", exp_setup.size(), 0);

    // tri_valid held through READY with params_ack withheld.
    resp_delay = 2;
    done_ord   = 1;
    exp_setup.push_back(3'd1);
    exp_we.push_back(3'd1);
    tri_valid = 1'b1;
    attr_mask = 8'h02;
    cyc = 0;
    while (!params_valid && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("hold_reach_ready", params_valid, 1);
    base_setup = n_setup;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!params_valid || tri_ready) bad++;
    end
    check("hold_no_reaccept", bad + (n_setup - base_setup), 0);
    attr_mask = 8'h00;
    params_ack = 1'b1;
    @(negedge clock);
    params_ack = 1'b0;
    check("hold_ack_idle", {params_valid, tri_ready}, 2'b01);
    @(negedge clock);
    tri_valid = 1'b0;
    check("hold_reaccept", tri_ready, 0);
    @(negedge clock);
    check("hold_empty_ready", params_valid, 1);
    params_ack = 1'b1;
    @(negedge clock);
    params_ack = 1'b0;
    check("hold_final_idle", tri_ready, 1);
    check("hold_sb_drained", exp_setup.size() + exp_we.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "simulation time limit");
  end

endmodule
